// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Upstream driver for the 3-to-8 decoder stage. Steps through the positions
// enabled in a mask, holding each one for a programmable dwell time. It can run
// as a continuous scan or as a single pass. It produces the decoder select and
// the decoder enable pair from a single clock.
//
// Enable code toward the decoder:
//   2'b10  active   (G1=1, G2=0)
//   2'b00  disabled
// No other code is ever driven.
//
// Optional feature (compile-time macro SCAN_BLANK_EN):
//   When defined, a BLANK gap of BLANK_CYCLES cycles with the decoder disabled
//   is inserted between consecutive positions. This prevents ghosting on the
//   decoded lines.
//   When undefined, the BLANK state and its counter are not built, and
//   positions follow each other with no gap.
//
// Parameters:
//   DWELL_W       width of iDwell and of the dwell counter
//   BLANK_CYCLES  length of the blanking gap, 1..255 (SCAN_BLANK_EN only)
//
// Ports:
//   iClk    clock; all logic is rising-edge
//   iRst    synchronous active-high reset
//   iRun    level; 1 = scanning requested
//   iMode   0 = continuous scan, 1 = single pass
//   iMask   bit k = 1 means position k is visited
//   iDwell  cycles per position (0 is treated as 1)
//   oSel    current position, feeds decoder iData
//   oEna    decoder enable pair, feeds decoder iEna
//   oBusy   high whenever the sequencer is not idle
//   oWrap   one-cycle pulse when the last enabled position of a pass ends
// -----------------------------------------------------------------------------
module scan_sequencer #(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iRun,
    input  logic               iMode,
    input  logic [7:0]         iMask,
    input  logic [DWELL_W-1:0] iDwell,
    output logic [2:0]         oSel,
    output logic [1:0]         oEna,
    output logic               oBusy,
    output logic               oWrap
);

    localparam logic [1:0] ENA_ACTIVE = 2'b10;
    localparam logic [1:0] ENA_OFF    = 2'b00;

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);
`else
    typedef enum logic [1:0] {IDLE, DWELL} state_t;

    // The gap length has no effect without the blanking feature. It is tied
    // off here so that the parameter still has a consumer.
    logic [7:0] unused_blank_len;
    assign unused_blank_len = 8'(BLANK_CYCLES - 1);
`endif

    // ------------------------------------------------------------------
    // Mask search helpers
    // ------------------------------------------------------------------

    // Returns the lowest set bit of m (0 when m is empty). Callers only use
    // the result when m is non-zero.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) idx = 3'(k);
        end
        return idx;
    endfunction

    // Returns 1 when m has a set bit strictly above position pos.
    function automatic logic has_above(input logic [7:0] m, input logic [2:0] pos);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (m[k] && (k > int'(pos))) found = 1'b1;
        end
        return found;
    endfunction

    // Returns the nearest set bit of m strictly above pos. The result is
    // valid only when has_above() is true.
    function automatic logic [2:0] next_above(input logic [7:0] m, input logic [2:0] pos);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k] && (k > int'(pos))) idx = 3'(k);
        end
        return idx;
    endfunction

    // Converts a dwell length into the counter start value. The counter counts
    // D-1 down to 0. A dwell of 0 is treated as 1. The subtraction never
    // exceeds the width, so the maximum dwell value cannot overflow.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic                 pending_q,   pending_d;   // start accepted; DWELL next edge
    logic [2:0]           target_q,    target_d;    // position to be shown next
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [2:0]           sel_d;
    logic [1:0]           ena_d;
    logic                 busy_d;
    logic                 wrap_d;
`ifdef SCAN_BLANK_EN
    logic [7:0]           blank_cnt_q, blank_cnt_d;
`endif

    // Scratch values for the end-of-dwell decision.
    logic                 wrapped;
    logic [2:0]           next_pos;

    // ------------------------------------------------------------------
    // Process 1: state register. All outputs are registered here too.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every register reading the pre-edge value of every other register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            target_q    <= 3'd0;
            dwell_cnt_q <= '0;
            oSel        <= 3'd0;
            oEna        <= ENA_OFF;
            oBusy       <= 1'b0;
            oWrap       <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_cnt_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            dwell_cnt_q <= dwell_cnt_d;
            oSel        <= sel_d;
            oEna        <= ena_d;
            oBusy       <= busy_d;
            oWrap       <= wrap_d;
`ifdef SCAN_BLANK_EN
            blank_cnt_q <= blank_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state and datapath logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first. A path that
    // forgets to assign a signal then holds the default instead of
    // inferring a latch.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        target_d    = target_q;
        dwell_cnt_d = dwell_cnt_q;
        sel_d       = oSel;
        wrap_d      = 1'b0;
        wrapped     = 1'b0;
        next_pos    = oSel;
`ifdef SCAN_BLANK_EN
        blank_cnt_d = blank_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    // The start was accepted on the previous edge. The
                    // position and dwell length were latched then.
                    state_d   = DWELL;
                    sel_d     = target_q;
                    pending_d = 1'b0;
                end else if (iRun && (iMask != 8'd0)) begin
                    pending_d   = 1'b1;
                    target_d    = lowest_set(iMask);
                    dwell_cnt_d = dwell_load(iDwell);
                end
            end

            DWELL: begin
                if (dwell_cnt_q != '0) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else if (!iRun || (iMask == 8'd0)) begin
                    // A stop request or an emptied mask ends the scan
                    // without a wrap pulse.
                    state_d = IDLE;
                end else begin
                    wrapped  = !has_above(iMask, oSel);
                    next_pos = wrapped ? lowest_set(iMask) : next_above(iMask, oSel);
                    wrap_d   = wrapped;
                    if (wrapped && iMode) begin
                        state_d = IDLE;
                    end else begin
                        dwell_cnt_d = dwell_load(iDwell);
`ifdef SCAN_BLANK_EN
                        // Keep the old position visible-but-disabled for
                        // the gap. Park the new position until the gap
                        // ends.
                        state_d     = BLANK;
                        target_d    = next_pos;
                        blank_cnt_d = BLANK_LOAD;
`else
                        state_d     = DWELL;
                        sel_d       = next_pos;
`endif
                    end
                end
            end

`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (blank_cnt_q != 8'd0) begin
                    blank_cnt_d = blank_cnt_q - 8'd1;
                end else if (!iRun || (iMask == 8'd0)) begin
                    state_d = IDLE;
                end else begin
                    // Show the position chosen at the end of the dwell,
                    // even if the mask changed during the gap.
                    state_d = DWELL;
                    sel_d   = target_q;
                end
            end
`endif

            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: output decode. The values are computed from the next state
    // so that the registered outputs line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        ena_d  = ENA_OFF;
        busy_d = 1'b0;
        if (state_d == DWELL) ena_d  = ENA_ACTIVE;
        if (state_d != IDLE)  busy_d = 1'b1;
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
//
// Self-checking bench for scan_sequencer.
//
// A sequential behavioural model predicts the four outputs for every cycle. It
// works by waiting for the start, dwelling, and choosing the next set bit. A
// compare process checks the DUT against the model on every falling edge.
//
// Directed scenarios add hand-computed literal expectations that pin down the
// model itself.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

    localparam int DW = 16;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          mode;
    logic [7:0]    mask;
    logic [DW-1:0] dwell;
    logic [2:0]    sel;
    logic [1:0]    ena;
    logic          busy;
    logic          wrap;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(DW), .BLANK_CYCLES(BC)) dut (
        .iClk   (clk),
        .iRst   (rst),
        .iRun   (run),
        .iMode  (mode),
        .iMask  (mask),
        .iDwell (dwell),
        .oSel   (sel),
        .oEna   (ena),
        .oBusy  (busy),
        .oWrap  (wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [2:0] m_sel  = 3'd0;
    logic [1:0] m_ena  = 2'b00;
    logic       m_busy = 1'b0;
    logic       m_wrap = 1'b0;

    function automatic int lowest_bit(input logic [7:0] m);
        for (int k = 0; k < 8; k++) if (m[k]) return k;
        return 0;
    endfunction

    function automatic int next_bit(input logic [7:0] m, input int p);
        for (int k = p + 1; k < 8; k++) if (m[k]) return k;
        return -1;
    endfunction

    // Advance the model by one rising edge. Reports whether reset was seen.
    task automatic step(output bit ab);
        @(posedge clk);
        m_wrap = 1'b0;
        ab = rst;
        if (rst) begin
            m_sel  = 3'd0;
            m_ena  = 2'b00;
            m_busy = 1'b0;
        end
    endtask

    task automatic go_idle();
        m_ena  = 2'b00;
        m_busy = 1'b0;
    endtask

    initial begin : model
        bit ab;
        bit go;
        int pos;
        int nxt;
        int dw;
        forever begin
            step(ab);
            if (ab || !run || (mask == 8'd0)) continue;
            pos = lowest_bit(mask);
            dw  = (dwell == 0) ? 1 : int'(dwell);
            step(ab);
            if (ab) continue;
            m_sel  = 3'(pos);
            m_ena  = 2'b10;
            m_busy = 1'b1;
            go = 1'b1;
            while (go) begin
                for (int c = 1; c < dw && !ab; c++) step(ab);
                if (ab) break;
                step(ab);
                if (ab) break;
                if (!run || (mask == 8'd0)) begin
                    go_idle();
                    go = 1'b0;
                end else begin
                    nxt = next_bit(mask, pos);
                    if (nxt < 0) begin
                        nxt    = lowest_bit(mask);
                        m_wrap = 1'b1;
                        if (mode) begin
                            go_idle();
                            go = 1'b0;
                        end
                    end
                    if (go) begin
                        dw = (dwell == 0) ? 1 : int'(dwell);
`ifdef SCAN_BLANK_EN
                        m_ena = 2'b00;
                        for (int b = 1; b < BC && !ab; b++) step(ab);
                        if (ab) break;
                        step(ab);
                        if (ab) break;
                        if (!run || (mask == 8'd0)) begin
                            go_idle();
                            go = 1'b0;
                        end else begin
                            pos   = nxt;
                            m_sel = 3'(pos);
                            m_ena = 2'b10;
                        end
`else
                        pos   = nxt;
                        m_sel = 3'(pos);
`endif
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle-by-cycle compare against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        check("model_sel",  32'(sel),  32'(m_sel));
        check("model_ena",  32'(ena),  32'(m_ena));
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_wrap", 32'(wrap), 32'(m_wrap));
    end

    // Wait (bounded) for the sequencer to go idle.
    task automatic wait_idle(input int max_cycles);
        for (int k = 0; k < max_cycles && busy; k++) @(negedge clk);
        check("idle_reached", 32'(busy), 0);
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    int sp_sel [6] = '{1, 1, 4, 4, 7, 7};
    int wraps;

    initial begin : stimulus
        rst   = 1'b1;
        run   = 1'b1;
        mode  = 1'b0;
        mask  = 8'hFF;
        dwell = 16'd3;

        // Reset held for three edges while run is requested.
        repeat (3) @(negedge clk);
        check("rst_ena",  32'(ena),  0);
        check("rst_sel",  32'(sel),  0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("start_gap_ena",  32'(ena),  0);
        check("start_gap_busy", 32'(busy), 0);
        @(negedge clk);
        check("first_dwell_ena",  32'(ena),  2);
        check("first_dwell_sel",  32'(sel),  0);
        check("first_dwell_busy", 32'(busy), 1);

`ifndef SCAN_BLANK_EN
        // Continuous scan, full mask, dwell 3.
        wraps = 0;
        for (int i = 0; i < 49; i++) begin
            if (i > 0) @(negedge clk);
            check("cont_sel", 32'(sel), (i / 3) % 8);
            check("cont_ena", 32'(ena), 2);
            if (wrap) wraps++;
        end
        check("cont_wraps", wraps, 2);
        run = 1'b0;
        wait_idle(20);

        // Sparse mask, single pass.
        mask = 8'b1001_0010; dwell = 16'd2; mode = 1'b1; run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("sp_ena", 32'(ena), (i >= 1 && i <= 6) ? 2 : 0);
            if (i >= 1 && i <= 6) check("sp_sel", 32'(sel), sp_sel[i-1]);
            check("sp_wrap", 32'(wrap), (i == 7) ? 1 : 0);
            if (i == 7) begin
                check("sp_busy", 32'(busy), 0);
                check("sp_sel_hold", 32'(sel), 7);
                run = 1'b0;
            end
        end

        // Stop requested on dwell cycle 3 of a 10-cycle dwell.
        mask = 8'hFF; dwell = 16'd10; mode = 1'b0; run = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 3) run = 1'b0;
            check("stop_ena", 32'(ena), (i >= 1 && i <= 10) ? 2 : 0);
            if (i >= 1 && i <= 10) check("stop_sel", 32'(sel), 0);
        end

        // Dwell 0 behaves as one cycle per position (single pass).
        dwell = 16'd0; mode = 1'b1; run = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("d0_ena", 32'(ena), (i >= 1 && i <= 8) ? 2 : 0);
            if (i >= 1 && i <= 8) check("d0_sel", 32'(sel), i - 1);
            check("d0_wrap", 32'(wrap), (i == 9) ? 1 : 0);
            if (i == 9) run = 1'b0;
        end

        // Mask cleared during position 2, then a single-bit mask.
        mask = 8'hFF; dwell = 16'd2; mode = 1'b0; run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 5) mask = 8'h00;
            check("clr_ena",  32'(ena),  (i >= 1 && i <= 6) ? 2 : 0);
            if (i >= 1 && i <= 6) check("clr_sel", 32'(sel), (i - 1) / 2);
            check("clr_wrap", 32'(wrap), 0);
            if (i == 7) check("clr_sel_hold", 32'(sel), 2);
        end
        mask = 8'h20;
        for (int i = 9; i < 18; i++) begin
            @(negedge clk);
            check("one_ena", 32'(ena), (i >= 10) ? 2 : 0);
            if (i >= 10) check("one_sel", 32'(sel), 5);
            check("one_wrap", 32'(wrap), (i >= 12 && i % 2 == 0) ? 1 : 0);
        end

        // Reset in the middle of a dwell aborts at once, with no wrap.
        rst = 1'b1;
        @(negedge clk);
        check("abort_ena",  32'(ena),  0);
        check("abort_sel",  32'(sel),  0);
        check("abort_busy", 32'(busy), 0);
        check("abort_wrap", 32'(wrap), 0);
        rst = 1'b0;
        @(negedge clk);
        check("restart_gap_ena", 32'(ena), 0);
        @(negedge clk);
        check("restart_ena", 32'(ena), 2);
        check("restart_sel", 32'(sel), 5);
        run = 1'b0;
        wait_idle(10);
`else
        // Blanking gap between positions.
        run = 1'b0;
        wait_idle(20);
        mask = 8'h03; dwell = 16'd2; mode = 1'b0; run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("blank_ena", 32'(ena), (i == 1 || i == 2 || i == 7 || i == 8) ? 2 : 0);
            if (i >= 1) check("blank_sel", 32'(sel), (i >= 7) ? 1 : 0);
            check("blank_wrap", 32'(wrap), (i == 9) ? 1 : 0);
        end
        run = 1'b0;
        wait_idle(20);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for the 3-to-8 decoder stage. Generates the decoder select (oSel → decoder iData) and the decoder enable pair (oEna → decoder iEna) from one clock.
- Steps through enabled positions 0..7 with a programmable dwell time per position, either as a continuous scan or a single pass.
- Drives the decoder disabled whenever no position is being shown.
- Enable encoding toward the decoder: 2'b10 (G1=1, G2=0) means active; 2'b00 means disabled. No other code is ever driven.

Parameters:
- DWELL_W, 16, width of the dwell-length input and the internal dwell counter.
- BLANK_CYCLES, 4, length of the inter-position blanking gap (only used with SCAN_BLANK_EN); legal range 1..255.

Ports:
- iClk  input  1  clock; all logic is rising-edge.
- iRst  input  1  reset, synchronous, active-high.
- iRun  input  1  level; 1 = scanning requested.
- iMode  input  1  0 = continuous scan, 1 = single pass.
- iMask  input  8  bit k = 1 means position k is visited.
- iDwell  input  DWELL_W  cycles per position; value 0 is treated as 1.
- oSel  output  3  current position, feeds decoder iData.
- oEna  output  2  decoder enable, feeds decoder iEna; only 2'b10 or 2'b00.
- oBusy  output  1  high in any state other than IDLE.
- oWrap  output  1  one-cycle pulse when the dwell of the last enabled position in a pass ends.

Behaviour:
- All outputs are registered.
- Reset values: oSel=3'b000, oEna=2'b00, oBusy=0, oWrap=0, state=IDLE, dwell counter=0.
- Reset mid-operation aborts immediately. The next cycle shows reset values, and no oWrap pulse is emitted.
- States: IDLE, DWELL, BLANK. BLANK exists only with SCAN_BLANK_EN.
- IDLE: oEna=00, oSel holds its last value.
  - If iRun=1 and iMask!=0 at edge N: position = lowest set bit of iMask, and iDwell is latched (0→1).
  - From edge N+1: state=DWELL, oEna=10, oSel=that position, oBusy=1.
  - If iMask=0, stay in IDLE.
- DWELL: oEna=10 for exactly D consecutive cycles, where D is the latched dwell. On the last dwell cycle, evaluate in this priority order:
  1. iRun=0 → IDLE.
  2. iMask=0 → IDLE, no oWrap.
  3. Otherwise compute next position = next set bit of the current iMask strictly above the current position. If there is none, wrap to the lowest set bit and assert oWrap for one cycle, aligned with the first non-dwell cycle.
  4. If wrapped and iMode=1 → IDLE.
  5. Otherwise → BLANK if the feature is present, else DWELL at the next position immediately, with no gap cycle and iDwell re-latched.
- iMask and iDwell are sampled only at position advance. Changes mid-dwell do not affect the current dwell.
- Mask with a single bit set: the same position repeats, and oWrap pulses at the end of every dwell.
- Deasserting iRun never truncates a dwell. oBusy falls on the cycle oEna returns to 00 and the state is IDLE.
- iRun reasserted on the same edge the block enters IDLE: the start is evaluated on the following edge (at least one IDLE cycle).
- Dwell counter: counts D-1 down to 0. The DWELL_W-bit maximum must not overflow.

Optional Feature:
- Macro SCAN_BLANK_EN.
- Defined: between consecutive positions the block enters BLANK for exactly BLANK_CYCLES cycles.
  - During BLANK: oEna=00, oSel holds the old position, then the next position is loaded.
  - iRun=0 during BLANK → IDLE at the end of the gap.
  - A mask re-check at the end of BLANK uses the already computed next position.
  - Prevents ghosting on the decoded lines.
- Undefined: BLANK state and its counter are not compiled. Transitions are direct DWELL→DWELL.

Test Plan:
- Reset: iRst=1 for 3 cycles while iRun=1 → oEna=00, oSel=000, oBusy=0; after release, the first DWELL starts 2 edges after iRst falls.
- Continuous, no blank: iMask=8'hFF, iDwell=3, iMode=0 → oSel sequence 0,0,0,1,1,1,…,7,7,7,0; oEna=10 throughout; oWrap pulses once per 24 cycles.
- Sparse mask, single pass: iMask=8'b1001_0010, iDwell=2, iMode=1 → oSel 1,1,4,4,7,7, then oEna=00, oBusy=0, oWrap pulse coinciding with the first IDLE cycle.
- Stop mid-dwell: iDwell=10, drop iRun on dwell cycle 3 → dwell completes all 10 cycles, then IDLE; iDwell=0 → one cycle per position.
- SCAN_BLANK_EN, BLANK_CYCLES=4, iMask=8'h03, iDwell=2 → oEna pattern 10,10,00,00,00,00,10,10; oSel stays 0 during the gap, then 1.
- Mask cleared mid-scan (iMask 8'hFF→8'h00 during position 2) → dwell of 2 finishes, IDLE, no oWrap; single-bit mask 8'h20 → oSel constant 5, oWrap every dwell.
